// File: rtl/conv_frame_seq_if.sv
// Byte-stream, datapath-strobe and UART-pacing signals of the
// convolution frame sequencer, grouped for module ports.
interface conv_frame_seq_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       kern_we;
  logic [4:0] kern_addr;
  logic [7:0] kern_data;
  logic       pix_we;
  logic [7:0] pix_data;
  logic [1:0] pix_ch;
  logic       win_valid;
  logic       res_valid;
  logic [7:0] res_data;
  logic       tx_busy;
  logic       send_we;
  logic [7:0] tx_data;
  logic       overrun;
  logic       frame_done;
  logic [2:0] state;

  modport master (
    output rx_valid, rx_data, res_valid, res_data, tx_busy,
    input  kern_we, kern_addr, kern_data, pix_we, pix_data,
    input  pix_ch, win_valid, send_we, tx_data, overrun,
    input  frame_done, state
  );

  modport slave (
    input  rx_valid, rx_data, res_valid, res_data, tx_busy,
    output kern_we, kern_addr, kern_data, pix_we, pix_data,
    output pix_ch, win_valid, send_we, tx_data, overrun,
    output frame_done, state
  );
endinterface

// File: rtl/conv_frame_seq.sv
// Frame sequencer: parses sync/kernel/pixel bytes from the UART
// receiver and paces datapath results into the UART transmitter.
module conv_frame_seq #(
  parameter int IMG_W = 502,
  parameter int IMG_H = 502,
  parameter int CH    = 3,
  parameter int KSIZE = 3
) (
  input logic             clk,
  input logic             rst,
  conv_frame_seq_if.slave bus
);
  localparam int KBYTES = KSIZE * KSIZE * CH;
  localparam int NOUT   = (IMG_W - KSIZE + 1) * (IMG_H - KSIZE + 1) * CH;
  localparam int KW = $clog2(KBYTES + 1);
  localparam int CW = $clog2(CH + 1);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);

  localparam logic [KW-1:0] K_LAST   = KW'(KBYTES - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(CH - 1);
  localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] COL_MIN  = XW'(KSIZE - 1);
  localparam logic [YW-1:0] ROW_MIN  = YW'(KSIZE - 1);
  localparam logic [19:0]   OUT_ALL  = 20'(NOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KERNEL = 3'd1,
    S_PIXEL  = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        r_state;
  logic [KW-1:0] r_kcnt;
  logic [CW-1:0] r_ch;
  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;
  logic [19:0]   r_out_cnt;
  logic          r_kern_we;
  logic [4:0]    r_kern_addr;
  logic [7:0]    r_kern_data;
  logic          r_pix_we;
  logic [7:0]    r_pix_data;
  logic [1:0]    r_pix_ch;
  logic          r_win_valid;
  logic          r_frame_done;
  logic          r_send_we;
  logic [7:0]    r_tx_data;
  logic          r_pend;
  logic [7:0]    r_pbuf;
  logic          r_overrun;

  logic w_send;
  logic w_from_pend;
  logic w_direct;
  logic w_store;
  logic w_drop;
  logic w_px_last;

  // r_send_we blocks back-to-back sends: tx_busy lags send_we by a cycle
  assign w_send      = !bus.tx_busy && !r_send_we
                       && (r_pend || bus.res_valid);
  assign w_from_pend = w_send && r_pend;
  assign w_direct    = w_send && !r_pend;
  assign w_store     = bus.res_valid && !w_direct
                       && (!r_pend || w_from_pend);
  assign w_drop      = bus.res_valid && !w_direct
                       && r_pend && !w_from_pend;
  assign w_px_last   = (r_ch == CH_LAST) && (r_col == COL_LAST)
                       && (r_row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_kcnt       <= '0;
      r_ch         <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_out_cnt    <= '0;
      r_kern_we    <= 1'b0;
      r_kern_addr  <= '0;
      r_kern_data  <= '0;
      r_pix_we     <= 1'b0;
      r_pix_data   <= '0;
      r_pix_ch     <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_kern_we    <= 1'b0;
      r_pix_we     <= 1'b0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_send) r_out_cnt <= r_out_cnt + 20'd1;
      unique case (r_state)
        S_IDLE: begin
          if (bus.rx_valid) r_state <= S_KERNEL;
        end
        S_KERNEL: begin
          if (bus.rx_valid) begin
            r_kern_we   <= 1'b1;
            r_kern_addr <= 5'(r_kcnt);
            r_kern_data <= bus.rx_data;
            r_kcnt      <= r_kcnt + KW'(1);
            if (r_kcnt == K_LAST) begin
              r_kcnt  <= '0;
              r_state <= S_PIXEL;
            end
          end
        end
        S_PIXEL: begin
          if (bus.rx_valid) begin
            r_pix_we    <= 1'b1;
            r_pix_data  <= bus.rx_data;
            r_pix_ch    <= 2'(r_ch);
            r_win_valid <= (r_row >= ROW_MIN) && (r_col >= COL_MIN);
            if (r_ch == CH_LAST) begin
              r_ch <= '0;
              if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + YW'(1);
              end else begin
                r_col <= r_col + XW'(1);
              end
            end else begin
              r_ch <= r_ch + CW'(1);
            end
            if (w_px_last) begin
              r_row   <= '0;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_out_cnt == OUT_ALL) r_state <= S_DONE;
        end
        S_DONE: begin
          r_frame_done <= 1'b1;
          r_state      <= S_IDLE;
          r_kcnt       <= '0;
          r_ch         <= '0;
          r_col        <= '0;
          r_row        <= '0;
          r_out_cnt    <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // One-entry pending slot: pbuf drains first, res_data bypasses when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_send_we <= 1'b0;
      r_tx_data <= '0;
      r_pend    <= 1'b0;
      r_pbuf    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_send_we <= w_send;
      if (w_send) r_tx_data <= r_pend ? r_pbuf : bus.res_data;
      if (w_store) begin
        r_pend <= 1'b1;
        r_pbuf <= bus.res_data;
      end else if (w_from_pend) begin
        r_pend <= 1'b0;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign bus.kern_we    = r_kern_we;
  assign bus.kern_addr  = r_kern_addr;
  assign bus.kern_data  = r_kern_data;
  assign bus.pix_we     = r_pix_we;
  assign bus.pix_data   = r_pix_data;
  assign bus.pix_ch     = r_pix_ch;
  assign bus.win_valid  = r_win_valid;
  assign bus.send_we    = r_send_we;
  assign bus.tx_data    = r_tx_data;
  assign bus.overrun    = r_overrun;
  assign bus.frame_done = r_frame_done;
  assign bus.state      = r_state;
endmodule

// File: tb/tb_conv_frame_seq.sv
// Bench for conv_frame_seq: vector table for parsing, hand sequences
// for pacing corners, randomized frames against a reference model.
module tb_conv_frame_seq;
  localparam int W = 4;
  localparam int H = 4;
  localparam int C = 1;
  localparam int K = 3;
  localparam int KB = K * K * C;
  localparam int NP = W * H * C;
  localparam int NOUT = (W - K + 1) * (H - K + 1) * C;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_frame_seq_if bus();

  conv_frame_seq #(
    .IMG_W(W), .IMG_H(H), .CH(C), .KSIZE(K)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] rx;
    logic       kwe;
    logic [4:0] kaddr;
    logic       pwe;
    logic       win;
    logic [2:0] st;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0]  sentq[$];
  logic [7:0]  expq[$];
  logic [15:0] kq[$];
  logic [8:0]  pixq[$];
  int fd_cnt = 0;
  int viol = 0;
  bit prev_send = 1'b0;
  bit auto_tx = 1'b0;
  int busy_left = 0;
  int issued = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    logic b;
    b = bus.tx_busy;
    @(posedge clk);
    #1;
    if (bus.send_we) begin
      sentq.push_back(bus.tx_data);
      if (b || prev_send) viol++;
    end
    prev_send = bus.send_we;
    if (bus.frame_done) fd_cnt++;
    if (bus.kern_we) kq.push_back({3'b0, bus.kern_addr, bus.kern_data});
    if (bus.pix_we) pixq.push_back({bus.win_valid, bus.pix_data});
    if (auto_tx) begin
      if (bus.send_we) begin
        bus.tx_busy = 1'b1;
        busy_left = $urandom_range(1, 4);
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.tx_busy = 1'b0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    tick();
    bus.rx_valid = 1'b0;
    tick();
  endtask

  task automatic res_pulse(input logic [7:0] d);
    bus.res_valid = 1'b1;
    bus.res_data = d;
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Random tick: may issue one result once all earlier ones have left
  task automatic rtick();
    logic [7:0] d;
    if (issued < NOUT && issued == sentq.size()
        && $urandom_range(0, 3) == 0) begin
      d = 8'($urandom);
      bus.res_valid = 1'b1;
      bus.res_data = d;
      expq.push_back(d);
      issued++;
    end
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic rbyte(input logic [7:0] b);
    int g;
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    rtick();
    bus.rx_valid = 1'b0;
    g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) rtick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[KB + NP + 1];
    logic [7:0] kb[KB];
    logic [7:0] pb[NP];
    int fd0;

    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.res_valid = 1'b0;
    bus.res_data = '0;
    bus.tx_busy = 1'b0;
    rst = 1'b0;

    tv[0].rx = 8'hAA; tv[0].kwe = 1'b0; tv[0].kaddr = '0;
    tv[0].pwe = 1'b0; tv[0].win = 1'b0; tv[0].st = 3'd1;
    for (int k = 0; k < KB; k++) begin
      tv[1+k].rx = 8'(k + 1);
      tv[1+k].kwe = 1'b1;
      tv[1+k].kaddr = 5'(k);
      tv[1+k].pwe = 1'b0;
      tv[1+k].win = 1'b0;
      tv[1+k].st = (k == KB - 1) ? 3'd2 : 3'd1;
    end
    for (int p = 0; p < NP; p++) begin
      tv[1+KB+p].rx = 8'(p);
      tv[1+KB+p].kwe = 1'b0;
      tv[1+KB+p].kaddr = '0;
      tv[1+KB+p].pwe = 1'b1;
      tv[1+KB+p].win = (p / W >= K - 1) && (p % W >= K - 1);
      tv[1+KB+p].st = (p == NP - 1) ? 3'd3 : 3'd2;
    end

    do_reset();
    chk("reset_state", bus.state, 0);
    chk("reset_outs", {bus.kern_we, bus.pix_we, bus.win_valid,
        bus.send_we, bus.overrun, bus.frame_done, bus.kern_addr,
        bus.kern_data, bus.pix_data, bus.pix_ch, bus.tx_data}, 0);

    for (int i = 0; i < KB + NP + 1; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = tv[i].rx;
      tick();
      bus.rx_valid = 1'b0;
      chk($sformatf("kern_we[%0d]", i), bus.kern_we, tv[i].kwe);
      if (tv[i].kwe) begin
        chk($sformatf("kern_addr[%0d]", i), bus.kern_addr, tv[i].kaddr);
        chk($sformatf("kern_data[%0d]", i), bus.kern_data, tv[i].rx);
      end
      chk($sformatf("pix_we[%0d]", i), bus.pix_we, tv[i].pwe);
      if (tv[i].pwe) begin
        chk($sformatf("pix_data[%0d]", i), bus.pix_data, tv[i].rx);
        chk($sformatf("pix_ch[%0d]", i), bus.pix_ch, 0);
        chk($sformatf("win_valid[%0d]", i), bus.win_valid, tv[i].win);
      end
      chk($sformatf("state[%0d]", i), bus.state, tv[i].st);
      tick();
      chk($sformatf("strobe_clr[%0d]", i),
          {bus.kern_we, bus.pix_we}, 0);
    end

    repeat (3) tick();
    chk("drain_hold", bus.state, 3);
    sentq.delete();
    fd_cnt = 0;
    for (int r = 0; r < NOUT; r++) begin
      res_pulse(8'hC0 + 8'(r));
      tick();
      tick();
    end
    repeat (5) tick();
    chk("t3_nsent", sentq.size(), NOUT);
    for (int r = 0; r < NOUT && r < sentq.size(); r++)
      chk($sformatf("t3_tx[%0d]", r), sentq[r], 8'hC0 + 8'(r));
    chk("t3_frame_done", fd_cnt, 1);
    chk("t3_state", bus.state, 0);
    chk("t3_overrun", bus.overrun, 0);

    sentq.delete();
    bus.tx_busy = 1'b1;
    res_pulse(8'h11);
    res_pulse(8'h22);
    tick();
    chk("t4_overrun", bus.overrun, 1);
    chk("t4_none_while_busy", sentq.size(), 0);
    bus.tx_busy = 1'b0;
    repeat (4) tick();
    chk("t4_nsent", sentq.size(), 1);
    if (sentq.size() > 0) chk("t4_tx", sentq[0], 8'h11);

    do_reset();
    chk("t5_overrun_clr", bus.overrun, 0);
    sentq.delete();
    bus.tx_busy = 1'b1;
    res_pulse(8'h33);
    bus.tx_busy = 1'b0;
    res_pulse(8'h44);
    chk("t5_send1", {bus.send_we, bus.tx_data}, {1'b1, 8'h33});
    tick();
    chk("t5_gap", bus.send_we, 0);
    tick();
    chk("t5_send2", {bus.send_we, bus.tx_data}, {1'b1, 8'h44});
    tick();
    chk("t5_overrun", bus.overrun, 0);
    chk("t5_nsent", sentq.size(), 2);

    do_reset();
    send_byte(8'hAA);
    for (int k = 0; k < KB; k++) send_byte(8'(k + 1));
    for (int p = 0; p < 8; p++) send_byte(8'(p));
    chk("t6_mid_pixel", bus.state, 2);
    rst = 1'b1;
    tick();
    chk("t6_state", bus.state, 0);
    chk("t6_outs", {bus.kern_we, bus.pix_we, bus.win_valid,
        bus.send_we, bus.overrun, bus.frame_done, bus.kern_addr,
        bus.kern_data, bus.pix_data, bus.pix_ch, bus.tx_data}, 0);
    rst = 1'b0;
    tick();
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h5A;
    tick();
    bus.rx_valid = 1'b0;
    chk("t6_sync_drop", {bus.kern_we, bus.state}, {1'b0, 3'd1});
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h77;
    tick();
    bus.rx_valid = 1'b0;
    chk("t6_kern0", {bus.kern_we, bus.kern_addr, bus.kern_data},
        {1'b1, 5'd0, 8'h77});

    do_reset();
    bus.tx_busy = 1'b0;
    busy_left = 0;
    auto_tx = 1'b1;
    viol = 0;
    for (int f = 0; f < 3; f++) begin
      kq.delete();
      pixq.delete();
      sentq.delete();
      expq.delete();
      issued = 0;
      fd0 = fd_cnt;
      for (int k = 0; k < KB; k++) kb[k] = 8'($urandom);
      for (int p = 0; p < NP; p++) pb[p] = 8'($urandom);
      rbyte(8'($urandom));
      for (int k = 0; k < KB; k++) rbyte(kb[k]);
      for (int p = 0; p < NP; p++) rbyte(pb[p]);
      for (int t = 0; t < 400 && fd_cnt == fd0; t++) rtick();
      repeat (2) tick();
      chk($sformatf("rf%0d_frame_done", f), fd_cnt - fd0, 1);
      chk($sformatf("rf%0d_state", f), bus.state, 0);
      chk($sformatf("rf%0d_nkern", f), kq.size(), KB);
      for (int k = 0; k < KB && k < kq.size(); k++)
        chk($sformatf("rf%0d_kern[%0d]", f, k), kq[k],
            {3'b0, 5'(k), kb[k]});
      chk($sformatf("rf%0d_npix", f), pixq.size(), NP);
      for (int p = 0; p < NP && p < pixq.size(); p++)
        chk($sformatf("rf%0d_pix[%0d]", f, p), pixq[p],
            {((p / (W * C)) >= K - 1) && (((p / C) % W) >= K - 1),
             pb[p]});
      chk($sformatf("rf%0d_nsent", f), sentq.size(), expq.size());
      for (int r = 0; r < expq.size() && r < sentq.size(); r++)
        chk($sformatf("rf%0d_tx[%0d]", f, r), sentq[r], expq[r]);
    end
    chk("rand_overrun", bus.overrun, 0);
    chk("rand_pacing_viol", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
